// File: rtl/audio_clk_pkg.sv
// rtl/audio_clk_pkg.sv - shared defaults and config clamp rules for audio_clkgen
package audio_clk_pkg;

  localparam int CFG_W_DEFAULT      = 8;
  localparam int MCLK_HALF_DEFAULT  = 4;
  localparam int SCLK_HALF_DEFAULT  = 2;
  localparam int FRAME_BITS_DEFAULT = 64;

  // A zero half-period would never terminate the counter, so it runs as 1.
  function automatic int unsigned clamp_half(input int unsigned v);
    return (v == 0) ? 32'd1 : v;
  endfunction

  // Frames need an even length of at least 2 so each lrck half is whole.
  function automatic int unsigned clamp_frame(input int unsigned v);
    int unsigned f;
    f = v & ~32'd1;
    return (f < 32'd2) ? 32'd2 : f;
  endfunction

endpackage

// File: rtl/audio_clkgen_if.sv
// rtl/audio_clkgen_if.sv - divider configuration bus for audio_clkgen
interface audio_clkgen_if import audio_clk_pkg::*; #(
  parameter int CFG_W = CFG_W_DEFAULT
);
  logic             cfg_ld;
  logic [CFG_W-1:0] cfg_mclk_half;
  logic [CFG_W-1:0] cfg_sclk_half;
  logic [CFG_W-1:0] cfg_frame_bits;
  logic             cfg_busy;

  modport master (
    output cfg_ld, cfg_mclk_half, cfg_sclk_half, cfg_frame_bits,
    input  cfg_busy
  );

  modport slave (
    input  cfg_ld, cfg_mclk_half, cfg_sclk_half, cfg_frame_bits,
    output cfg_busy
  );
endinterface

// File: rtl/clk_en_divider.sv
// rtl/clk_en_divider.sv - half-period counter on a tick enable with toggle output and edge strobes
module clk_en_divider import audio_clk_pkg::*; #(
  parameter int W = CFG_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         tick,
  input  logic [W-1:0] half,
  output logic         out,
  output logic         rise_stb,
  output logic         fall_stb,
  output logic         fall_now
);
  logic [W-1:0] cnt;
  logic         term;

  assign term     = (cnt == half - W'(1));
  // Combinational fall lets the next stage advance on the same clk edge.
  assign fall_now = tick & term & out;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt      <= '0;
      out      <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
    end else begin
      rise_stb <= tick & term & ~out;
      fall_stb <= fall_now;
      if (tick) begin
        if (term) begin
          cnt <= '0;
          out <= ~out;
        end else begin
          cnt <= cnt + W'(1);
        end
      end
    end
  end
endmodule

// File: rtl/audio_clkgen.sv
// rtl/audio_clkgen.sv - clock-enable based mclk/sclk/lrck generator with frame-aligned reconfiguration
module audio_clkgen import audio_clk_pkg::*; #(
  parameter int CFG_W          = CFG_W_DEFAULT,
  parameter int MCLK_HALF_DEF  = MCLK_HALF_DEFAULT,
  parameter int SCLK_HALF_DEF  = SCLK_HALF_DEFAULT,
  parameter int FRAME_BITS_DEF = FRAME_BITS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  audio_clkgen_if.slave    cfg,
  output logic             mclk,
  output logic             sclk,
  output logic             lrck,
  output logic             sclk_rise_stb,
  output logic             sclk_fall_stb,
  output logic             frame_stb,
  output logic [CFG_W-1:0] bit_idx
);
  localparam logic [CFG_W-1:0] DEF_M = CFG_W'(clamp_half($unsigned(MCLK_HALF_DEF)));
  localparam logic [CFG_W-1:0] DEF_S = CFG_W'(clamp_half($unsigned(SCLK_HALF_DEF)));
  localparam logic [CFG_W-1:0] DEF_F = CFG_W'(clamp_frame($unsigned(FRAME_BITS_DEF)));

  logic [CFG_W-1:0] act_m, act_s, act_f;
  logic [CFG_W-1:0] pend_m, pend_s, pend_f;
  logic [CFG_W-1:0] new_m, new_s, new_f;
  logic [CFG_W-1:0] lr_half;
  logic             busy, clr;
  logic             m_fall, s_fall, l_fall;
  logic             m_rise_stb, m_fall_stb, l_rise_stb;
  logic             unused_stb;

  assign new_m   = CFG_W'(clamp_half(32'(cfg.cfg_mclk_half)));
  assign new_s   = CFG_W'(clamp_half(32'(cfg.cfg_sclk_half)));
  assign new_f   = CFG_W'(clamp_frame(32'(cfg.cfg_frame_bits)));
  assign lr_half = act_f >> 1;

  // A load while stopped has no frame boundary to wait for, so it applies immediately.
  assign clr          = cfg.cfg_ld & ~en;
  assign cfg.cfg_busy = busy;
  assign unused_stb   = m_rise_stb ^ m_fall_stb ^ l_rise_stb;

  clk_en_divider #(.W(CFG_W)) u_mclk (
    .clk(clk), .rst(rst), .clr(clr), .tick(en), .half(act_m),
    .out(mclk), .rise_stb(m_rise_stb), .fall_stb(m_fall_stb), .fall_now(m_fall)
  );

  clk_en_divider #(.W(CFG_W)) u_sclk (
    .clk(clk), .rst(rst), .clr(clr), .tick(m_fall), .half(act_s),
    .out(sclk), .rise_stb(sclk_rise_stb), .fall_stb(sclk_fall_stb), .fall_now(s_fall)
  );

  clk_en_divider #(.W(CFG_W)) u_lrck (
    .clk(clk), .rst(rst), .clr(clr), .tick(s_fall), .half(lr_half),
    .out(lrck), .rise_stb(l_rise_stb), .fall_stb(frame_stb), .fall_now(l_fall)
  );

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      bit_idx <= '0;
    end else if (s_fall) begin
      bit_idx <= (bit_idx == act_f - CFG_W'(1)) ? '0 : bit_idx + CFG_W'(1);
    end
  end

  // On the lrck fall every counter wraps to 0 by itself, so swapping the
  // active values on that edge restarts the new timing cleanly. A load on
  // the same edge lands in the shadow and waits for the next boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_m  <= DEF_M;
      act_s  <= DEF_S;
      act_f  <= DEF_F;
      pend_m <= '0;
      pend_s <= '0;
      pend_f <= '0;
      busy   <= 1'b0;
    end else if (clr) begin
      act_m <= new_m;
      act_s <= new_s;
      act_f <= new_f;
      busy  <= 1'b0;
    end else begin
      if (l_fall && busy) begin
        act_m <= pend_m;
        act_s <= pend_s;
        act_f <= pend_f;
        busy  <= 1'b0;
      end
      if (cfg.cfg_ld) begin
        pend_m <= new_m;
        pend_s <= new_s;
        pend_f <= new_f;
        busy   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_audio_clkgen.sv
// tb/tb_audio_clkgen.sv - randomized self-checking bench for audio_clkgen against a time-based model
module tb_audio_clkgen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       mclk, sclk, lrck;
  logic       sclk_rise_stb, sclk_fall_stb, frame_stb;
  logic [7:0] bit_idx;

  audio_clkgen_if #(.CFG_W(8)) cfg_bus ();

  audio_clkgen #(
    .CFG_W(8), .MCLK_HALF_DEF(4), .SCLK_HALF_DEF(2), .FRAME_BITS_DEF(64)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cfg(cfg_bus),
    .mclk(mclk), .sclk(sclk), .lrck(lrck),
    .sclk_rise_stb(sclk_rise_stb), .sclk_fall_stb(sclk_fall_stb),
    .frame_stb(frame_stb), .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: t = enabled clk edges since the last restart; all outputs follow from t.
  int t = 0, mh = 4, sh = 2, fb = 64;
  int pm = 0, ps = 0, pf = 0, mbusy = 0;
  int e_sr = 0, e_sf = 0, e_fr = 0;
  int cyc = 0, en_rise = 0, track = 0, first_frame = -1;
  int last_frame = 0, frame_gap = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int ref_half(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int ref_frame(input int v);
    int f;
    f = (v / 2) * 2;
    return (f < 2) ? 2 : f;
  endfunction

  task automatic model_step();
    int hs;
    int ld;
    ld = int'(cfg_bus.cfg_ld);
    if (rst) begin
      mh = 4; sh = 2; fb = 64; mbusy = 0; t = 0;
      e_sr = 0; e_sf = 0; e_fr = 0;
    end else if (ld != 0 && !en) begin
      mh = ref_half(int'(cfg_bus.cfg_mclk_half));
      sh = ref_half(int'(cfg_bus.cfg_sclk_half));
      fb = ref_frame(int'(cfg_bus.cfg_frame_bits));
      t = 0; mbusy = 0;
      e_sr = 0; e_sf = 0; e_fr = 0;
    end else if (en) begin
      t++;
      hs   = 2 * mh * sh;
      e_sr = (t % hs == 0 && (t / hs) % 2 == 1) ? 1 : 0;
      e_sf = (t % hs == 0 && (t / hs) % 2 == 0) ? 1 : 0;
      e_fr = (t % (2 * hs * fb) == 0) ? 1 : 0;
      if (e_fr != 0 && mbusy != 0) begin
        mh = pm; sh = ps; fb = pf; t = 0; mbusy = 0;
      end
      if (ld != 0) begin
        pm = ref_half(int'(cfg_bus.cfg_mclk_half));
        ps = ref_half(int'(cfg_bus.cfg_sclk_half));
        pf = ref_frame(int'(cfg_bus.cfg_frame_bits));
        mbusy = 1;
      end
    end else begin
      e_sr = 0; e_sf = 0; e_fr = 0;
    end
  endtask

  task automatic step();
    int hs, bi;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    hs = 2 * mh * sh;
    bi = (t / (2 * hs)) % fb;
    check("mclk", 32'(mclk), (t / mh) % 2);
    check("sclk", 32'(sclk), (t / hs) % 2);
    check("bit_idx", 32'(bit_idx), bi);
    check("lrck", 32'(lrck), (bi >= fb / 2) ? 1 : 0);
    check("sclk_rise_stb", 32'(sclk_rise_stb), e_sr);
    check("sclk_fall_stb", 32'(sclk_fall_stb), e_sf);
    check("frame_stb", 32'(frame_stb), e_fr);
    check("cfg_busy", 32'(cfg_bus.cfg_busy), mbusy);
    if (frame_stb === 1'b1) begin
      if (track != 0 && first_frame < 0) first_frame = cyc - en_rise;
      frame_gap  = cyc - last_frame;
      last_frame = cyc;
    end
  endtask

  task automatic load(input int m, input int s, input int f);
    cfg_bus.cfg_ld         = 1'b1;
    cfg_bus.cfg_mclk_half  = 8'(m);
    cfg_bus.cfg_sclk_half  = 8'(s);
    cfg_bus.cfg_frame_bits = 8'(f);
    step();
    cfg_bus.cfg_ld = 1'b0;
  endtask

  initial begin
    int found;
    cfg_bus.cfg_ld         = 1'b0;
    cfg_bus.cfg_mclk_half  = '0;
    cfg_bus.cfg_sclk_half  = '0;
    cfg_bus.cfg_frame_bits = '0;

    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // Default timing from the en rise.
    en = 1'b1; en_rise = cyc; track = 1;
    repeat (2100) step();
    check("first_frame_stb_delay", 32'(first_frame), 2048);
    track = 0;

    // Mid-frame runtime load: old timing until the boundary, then the new one.
    repeat (300) step();
    load(2, 4, 32);
    repeat (3300) step();
    check("runtime_lrck_period", 32'(frame_gap), 1024);

    // Gate for 100 cycles mid-frame.
    repeat (500) step();
    en = 1'b0;
    repeat (100) step();
    en = 1'b1;
    repeat (500) step();

    // Clamp 0/0/3 while stopped.
    en = 1'b0;
    load(0, 0, 3);
    en = 1'b1;
    repeat (40) step();
    check("clamp_lrck_period", 32'(frame_gap), 8);

    // Reset while a load is pending.
    load(3, 1, 6);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (100) step();

    // Load coincident with frame_stb waits for the following boundary.
    load(1, 1, 4);
    found = 0;
    for (int i = 0; i < 5000 && found == 0; i++) begin
      step();
      if (e_fr != 0 && mbusy == 0) found = 1;
    end
    check("wait_frame_boundary", 32'(found), 1);
    load(1, 2, 4);
    repeat (200) step();

    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end else if (r <= 4) begin
        en = ($urandom_range(0, 3) != 0);
        load($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 9));
      end else begin
        en = ($urandom_range(0, 3) != 0);
      end
      repeat ($urandom_range(1, 300)) step();
    end
    en = 1'b1;
    repeat (400) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/audio_clkgen.md
AUDIO_CLKGEN -- requirements
Module: audio_clkgen

Interface
REQ-001 SHALL have parameter MCLK_HALF_DEF, default 4, reset-time MCLK half-period in clk cycles (100 MHz clk -> 12.5 MHz mclk).
REQ-002 SHALL have parameter SCLK_HALF_DEF, default 2, reset-time SCLK half-period in MCLK periods.
REQ-003 SHALL have parameter FRAME_BITS_DEF, default 64, reset-time SCLK periods per LRCK period.
REQ-004 SHALL have parameter CFG_W, default 8, width of every cfg_* field.
REQ-005 SHALL have port clk  input  1  system clock; the block has this one clock only.
REQ-006 SHALL have port rst  input  1  reset, synchronous to clk, active-high.
REQ-007 SHALL have port en  input  1  run enable; low freezes all counters and outputs.
REQ-008 SHALL have port cfg_ld  input  1  one-cycle request to load new divider values.
REQ-009 SHALL have ports cfg_mclk_half, cfg_sclk_half, cfg_frame_bits  input  CFG_W each  new divider values, sampled when cfg_ld=1.
REQ-010 SHALL have port cfg_busy  output  1  high while a loaded config is pending.
REQ-011 SHALL have ports mclk, sclk, lrck  output  1 each  registered audio clocks.
REQ-012 SHALL have ports sclk_rise_stb, sclk_fall_stb, frame_stb  output  1 each  one-clk pulses coincident with the matching output edge.
REQ-013 SHALL have port bit_idx  output  CFG_W  index of the current SCLK period within the frame, 0..frame_bits-1.

Function
REQ-014 mclk SHALL toggle when the clk-cycle counter reaches mclk_half-1 with en=1; the counter then wraps to 0.
REQ-015 The SCLK counter SHALL advance only in cycles where mclk goes 1->0; sclk SHALL toggle when it reaches sclk_half-1, then wrap.
REQ-016 sclk_fall_stb SHALL be high in exactly the clk cycle in which sclk becomes 0; sclk_rise_stb likewise for sclk becoming 1.
REQ-017 bit_idx SHALL increment on each sclk fall and wrap from frame_bits-1 to 0.
REQ-018 lrck SHALL go 1 on the sclk fall where bit_idx wraps to frame_bits/2, and go 0 on the sclk fall where bit_idx wraps to 0.
REQ-019 frame_stb SHALL pulse in the cycle lrck goes 1->0.
REQ-020 With en=0, all counters, mclk, sclk, lrck and bit_idx SHALL hold; all strobes SHALL be 0.
REQ-021 A config value of 0 SHALL be treated as 1; an odd cfg_frame_bits SHALL round down; a frame_bits below 2 SHALL become 2.
REQ-022 On cfg_ld with en=1, the values SHALL be captured into shadow registers and cfg_busy SHALL rise the next cycle.
REQ-023 A pending config SHALL become active in the frame_stb cycle; all counters SHALL restart at 0 with the new values from the next cycle, and cfg_busy SHALL fall.
REQ-024 On cfg_ld with en=0, the config SHALL apply at once: counters and outputs clear to 0 next cycle, and cfg_busy stays 0.
REQ-025 A cfg_ld while cfg_busy=1 SHALL overwrite the pending values; the last load wins.
REQ-026 A cfg_ld in the same cycle as frame_stb SHALL be held pending for the following frame boundary.

Reset
REQ-027 On rst=1 at a clk edge, mclk, sclk, lrck, bit_idx, all strobes, cfg_busy and all counters SHALL be 0.
REQ-028 On reset, the active config SHALL be *_DEF and any pending config SHALL be discarded.
REQ-029 Reset SHALL take priority over en and cfg_ld, including mid-frame.

Structure
REQ-030 A shared package audio_clk_pkg SHALL hold the CFG_W default, the *_DEF defaults and the clamp rules as constants and functions.
REQ-031 One sub-module, clk_en_divider (programmable half-period counter with tick enable, toggle output and rise/fall strobes), SHALL be instantiated for the mclk, sclk and lrck stages.
REQ-032 No output SHALL be a derived clock used to clock logic inside the block; every flop SHALL be on clk.

Verification
REQ-033 Defaults, en=1 after reset, 4096 clk:
- mclk period 8 clk; sclk period 32 clk; lrck period 2048 clk;
- first frame_stb at clk 2048 after the en rise.
REQ-034 Runtime load with en=1 and mclk_half=2, sclk_half=4, frame_bits=32 loaded mid-frame:
- old timing until frame_stb, cfg_busy high until then;
- afterwards mclk period 4 clk, sclk period 32 clk, lrck period 1024 clk.
REQ-035 Clamping: load 0/0/3 with en=0 -> mclk period 2 clk, sclk period 4 clk, lrck period 8 clk.
REQ-036 Gating: en low for 100 clk mid-frame -> outputs and bit_idx frozen, no strobes; timing resumes seamlessly.
REQ-037 Reset cases:
- rst during cfg_busy=1 -> all outputs 0 next cycle and the default timing is restored;
- cfg_ld coincident with frame_stb -> applied at the next frame_stb, not the current one.
